// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU/mux select codes and the controller state type.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU operation class requested by the controller; FUNCT defers to the funct field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ALU decoder: maps ALU-op class and funct to an ALU control code plus a
// valid flag. Kept standalone so the pipelined core can reuse it.
module aludec
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     i_aluop,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alucontrol,
  output logic        o_valid
);

  always_comb begin
    o_alucontrol = ALU_AND;
    o_valid      = 1'b1;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          F_ADD:   o_alucontrol = ALU_ADD;
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_valid      = 1'b0;
        endcase
      end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core. Memory states stretch on
// mem_ready; write/enable strobes are held low while reset is asserted.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       lord,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  alu_op_t    w_aluop;
  logic [2:0] w_aluctl;
  logic       w_funct_valid;
  logic       w_mem_req, w_memwrite, w_irwrite, w_pcen, w_regwrite, w_illegal;

  aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (w_aluctl),
    .o_valid      (w_funct_valid)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // ALU-op selection lives apart from the main decode so it never reads its own output.
  always_comb begin
    w_aluop = ALUOP_ADD;
    case (r_state)
      S_EXECUTE: w_aluop = ALUOP_FUNCT;
      S_BRANCH:  w_aluop = ALUOP_SUB;
      default:   w_aluop = ALUOP_ADD;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next     = S_FETCH;
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    lord       = 1'b0;
    pcsrc      = PC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    alucontrol = 3'b000;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = w_aluctl;
        w_irwrite  = mem_ready;
        w_pcen     = mem_ready;
        w_next     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SH;
        alucontrol = w_aluctl;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = w_aluctl;
        w_next     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        lord      = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        lord       = 1'b1;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = w_aluctl;
        w_illegal  = !w_funct_valid;
        w_next     = w_funct_valid ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = w_aluctl;
        pcsrc      = PC_ALUOUT;
        w_pcen     = zero;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = w_aluctl;
        w_next     = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc  = PC_JUMP;
        w_pcen = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign mem_req  = reset & w_mem_req;
  assign memwrite = reset & w_memwrite;
  assign irwrite  = reset & w_irwrite;
  assign pcen     = reset & w_pcen;
  assign regwrite = reset & w_regwrite;
  assign illegal  = reset & w_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: builds the expected per-cycle control vectors for each
// instruction from its class and stall pattern, then compares every cycle.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       lord;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic ready;
    logic zbit;
    ctl_t ctl;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, irwrite, lord, pcen, alusrca;
  logic       regdst, memtoreg, regwrite, illegal;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;

  int    checks = 0;
  int    errors = 0;
  step_t exp_q[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .irwrite(irwrite), .lord(lord), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    return {mem_req, memwrite, irwrite, lord, pcen, pcsrc, alusrca, alusrcb,
            alucontrol, regdst, memtoreg, regwrite, illegal};
  endfunction

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ready, input logic zbit, input ctl_t c);
    step_t s;
    s.ready = ready;
    s.zbit  = zbit;
    s.ctl   = c;
    exp_q.push_back(s);
  endtask

  // Instruction fetch: PC+4 computed throughout, IR/PC load only on the ready cycle.
  task automatic add_fetch(input int stalls);
    ctl_t c = '0;
    c.mem_req    = 1'b1;
    c.alusrcb    = 2'b01;
    c.alucontrol = 3'b010;
    repeat (stalls) push(1'b0, rbit(), c);
    c.irwrite = 1'b1;
    c.pcen    = 1'b1;
    push(1'b1, rbit(), c);
  endtask

  task automatic add_mem(input int stalls, input logic wr);
    ctl_t c = '0;
    c.mem_req  = 1'b1;
    c.lord     = 1'b1;
    c.memwrite = wr;
    repeat (stalls) push(1'b0, rbit(), c);
    push(1'b1, rbit(), c);
  endtask

  function automatic logic [3:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b000};
    endcase
  endfunction

  task automatic plan_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic zb, input int fs, input int ms);
    ctl_t       c;
    logic [3:0] fc;
    logic       known;
    known = (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
            (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    add_fetch(fs);
    c = '0;
    c.alusrcb    = 2'b11;
    c.alucontrol = 3'b010;
    c.illegal    = !known;
    push(rbit(), rbit(), c);
    c = '0;
    case (o)
      6'b100011, 6'b101011: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
        push(rbit(), rbit(), c);
        add_mem(ms, o == 6'b101011);
        if (o == 6'b100011) begin
          c = '0; c.memtoreg = 1'b1; c.regwrite = 1'b1;
          push(rbit(), rbit(), c);
        end
      end
      6'b000000: begin
        fc = funct_code(f);
        c.alusrca = 1'b1; c.alucontrol = fc[2:0]; c.illegal = !fc[3];
        push(rbit(), rbit(), c);
        if (fc[3]) begin
          c = '0; c.regdst = 1'b1; c.regwrite = 1'b1;
          push(rbit(), rbit(), c);
        end
      end
      6'b000100: begin
        c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = zb;
        push(rbit(), zb, c);
      end
      6'b001000: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
        push(rbit(), rbit(), c);
        c = '0; c.regwrite = 1'b1;
        push(rbit(), rbit(), c);
      end
      6'b000010: begin
        c.pcsrc = 2'b10; c.pcen = 1'b1;
        push(rbit(), rbit(), c);
      end
      default: ;
    endcase
  endtask

  // Consumes up to n expected steps; inputs change 1 ns after the edge, outputs sampled mid-cycle.
  task automatic run_steps(input string name, input int n);
    step_t s;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      s = exp_q.pop_front();
      mem_ready = s.ready;
      zero      = s.zbit;
      #3;
      check($sformatf("%s c%0d", name, i), observed(), s.ctl);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic zb, input int fs, input int ms);
    op    = o;
    funct = f;
    plan_instr(o, f, zb, fs, ms);
    run_steps(name, exp_q.size());
  endtask

  ctl_t rst_vec;

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [6];
    rst_vec = '0;
    rst_vec.alusrcb    = 2'b01;
    rst_vec.alucontrol = 3'b010;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
            6'b001000, 6'b000010, 6'b111111, 6'b010101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110};

    reset = 1'b0; op = 6'b100011; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("reset c%0d", i), observed(), rst_vec);
      @(posedge clk); #1;
    end
    reset = 1'b1;

    run_instr("lw",       6'b100011, 6'b000000, 1'b0, 0, 0);
    run_instr("sw_stall", 6'b101011, 6'b000000, 1'b0, 1, 2);
    run_instr("slt",      6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr("bad_fn",   6'b000000, 6'b100110, 1'b0, 0, 0);
    run_instr("beq_t",    6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr("beq_nt",   6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr("bad_op",   6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr("j",        6'b000010, 6'b000000, 1'b0, 0, 0);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0, 2, 0);

    // Reset in the middle of a stalled lw read: FETCH at once, no write afterwards.
    op = 6'b100011;
    plan_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
    run_steps("lw_pre", 3);
    exp_q.delete();
    reset = 1'b0; mem_ready = 1'b0;
    #3;
    check("mid_reset a", observed(), rst_vec);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #3;
    check("mid_reset b", observed(), rst_vec);
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr("post_rst", 6'b001000, 6'b000000, 1'b0, 1, 0);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] ro, rf;
      ro = ops[$urandom_range(0, 7)];
      if (ro == 6'b010101) ro = 6'($urandom());
      rf = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rf = 6'($urandom());
      run_instr($sformatf("rnd%0d op%b", k, ro), ro, rf, rbit(),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    add_fetch(0);
    run_steps("tail", exp_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
